tx_frame_scheduler: RTL and testbench
=====================================

# tx_frame_scheduler

Sequences the 8b/10b fibre transmitter by sharing it between two byte-stream requesters and a link-test (PRBS) request. Frames are arbitrated round-robin; each frame becomes a header word, the payload bytes, an optional checksum word and a fixed idle gap. Bytes are delivered to the transmitter one per word slot, paced by the transmitter's read-enable strobe. The block sits directly upstream of `tx` in the `clk_bit` domain.

## Interface
Parameters:
- `MAX_LEN`, 64: maximum payload bytes per frame (1..255).
- `GAP_WORDS`, 2: idle word slots forced between frames (1..15).

Ports:
- `clk_bit` in 1: bit clock; the block's only clock.
- `rst` in 1: reset. Synchronous, active-high.
- `req0_data` in 8, `req0_valid` in 1, `req0_last` in 1: requester 0 byte stream; `last` marks the final payload byte.
- `req0_ready` out 1: requester 0 byte accepted when `req0_valid && req0_ready`.
- `req1_data`, `req1_valid`, `req1_last`, `req1_ready`: same for requester 1.
- `prbs_req` in 1: request PRBS link-test mode.
- `tx_read_enable` in 1: one-cycle strobe from `tx`, once per 10 `clk_bit`; the current `tx_d_in`/`tx_d_in_valid` are consumed on this cycle.
- `tx_d_in` out 8, `tx_d_in_valid` out 1: word to `tx`; invalid means `tx` sends idle.
- `tx_prbs_on` out 1: drives `tx` PRBS mode.
- `grant` out 2: one-hot owner of the frame in progress; 0 when none.
- `underrun` out 1: one-cycle pulse, see Operation.

## Operation
- Output holding register (OHR): `tx_d_in`, `tx_d_in_valid`. A word is loaded only when the OHR is empty or is being consumed this cycle (`tx_read_enable` high).
- States: IDLE, HEADER, PAYLOAD, TRAILER, GAP, PRBS.
- IDLE: if `prbs_req`, go to PRBS; prbs has priority over new frames but never preempts a frame. Else if any `reqN_valid`, grant: single requester wins; both valid, the requester not served last wins. After reset, requester 0 wins the first tie. Load header `{4'hA, 3'b000, n}` into the OHR and go to HEADER.
- HEADER: when the header is consumed, go to PAYLOAD.
- PAYLOAD: `reqN_ready` = granted and OHR loadable. Each accepted byte is loaded into the OHR. Byte counter is 8 bits and counts accepted bytes. The byte with `last`, or the MAX_LEN-th byte, ends the payload; go to TRAILER or GAP. `last` on the MAX_LEN-th byte ends one frame only. Bytes beyond MAX_LEN belong to the next frame.
- Underrun: in PAYLOAD, `tx_read_enable` with the OHR empty pulses `underrun`. `tx` sends idle for that slot; the frame continues.
- TRAILER: only when the checksum feature is compiled in. See Configuration.
- GAP: entered once the last frame word is consumed. The OHR is held invalid for `GAP_WORDS` `tx_read_enable` strobes, then the state goes to IDLE, `grant`=0, and the round-robin pointer updates.
- PRBS: `tx_prbs_on`=1 and OHR invalid while `prbs_req` is high. When it falls, `tx_prbs_on`=0 and the state goes to IDLE on the next edge.

## Timing
- Reset values: `tx_d_in`=0, `tx_d_in_valid`=0, `tx_prbs_on`=0, `grant`=0, `req0_ready`=`req1_ready`=0, `underrun`=0. After reset: state IDLE, counter 0, checksum 0, rr pointer = 1.
- All outputs are registered except `reqN_ready`, which is combinational from state, grant, OHR status and `tx_read_enable`.
- Grant latency: from `reqN_valid` rising in IDLE, `grant` and the header are in the OHR one edge later.
- Each word occupies exactly one `tx` slot (10 `clk_bit`).
- Frame on the line: 1 header + L payload + 0/1 checksum, followed by `GAP_WORDS` idle slots.
- Simultaneous consume and load in one cycle: the new word replaces the old with no bubble.
- `rst` mid-frame: the frame is abandoned and the OHR cleared on that edge. `tx` sends idle. Requesters must flush their partial frame.

## Configuration
- `TX_SCHED_CHECKSUM_EN` defined:
  - The TRAILER state exists.
  - After the final payload byte is consumed, an XOR checksum of header and payload bytes is sent as one word.
  - The checksum register clears on each header load.
- Not defined: TRAILER logic is absent; the final payload byte goes straight to GAP.

## Test plan
- Reset, no requests, 100 slots -> `tx_d_in_valid`=0, `tx_prbs_on`=0, `grant`=0 throughout.
- req0 frame 0x01,0x02,0x03 (last) -> line words 0xA0,0x01,0x02,0x03, then 0xA0 checksum if `TX_SCHED_CHECKSUM_EN` is defined. Then 2 idle slots; `grant`=01 during the frame.
- req0 and req1 valid simultaneously, each sending 2-byte frames -> order req0, req1, req0. Headers 0xA0, 0xA1, 0xA0.
- req1 streams 70 bytes with no `last`, MAX_LEN=64 -> first frame has 64 payload bytes. Second frame is headed 0xA1 and carries the remaining 6.
- req0 valid drops for 25 cycles mid-payload -> `underrun` pulses on each empty slot. Remaining bytes follow in order.
- `prbs_req` raised mid-frame -> frame completes including the gap, then `tx_prbs_on`=1. Lowering `prbs_req` clears `tx_prbs_on` one edge later. `rst` mid-frame clears all outputs on the next edge.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: shares the 8b/10b transmitter between two byte-stream
// requesters and a PRBS link-test request. Frames go out as header word,
// payload bytes, optional checksum word, then a fixed idle gap.
// Optional feature macro: TX_SCHED_CHECKSUM_EN (XOR checksum trailer word).
// Handshakes: a requester byte transfers on a clk_bit edge where
// reqN_valid && reqN_ready; tx consumes tx_d_in/tx_d_in_valid on an edge
// where tx_read_enable is high. Neither side may retract a presented item.
module tx_frame_scheduler #(
  parameter int MAX_LEN   = 64,
  parameter int GAP_WORDS = 2
) (
  input  logic       clk_bit,
  input  logic       rst,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  input  logic       prbs_req,
  input  logic       tx_read_enable,
  output logic [7:0] tx_d_in,
  output logic       tx_d_in_valid,
  output logic       tx_prbs_on,
  output logic [1:0] grant,
  output logic       underrun,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_TRAILER = 3'd3,
    S_GAP     = 3'd4,
    S_PRBS    = 3'd5
  } state_t;

  state_t     r_state, w_state_nxt;

  logic [7:0] r_d_in, w_d_in_nxt;
  logic       r_d_valid, w_d_valid_nxt;
  logic       r_prbs_on, w_prbs_on_nxt;
  logic [1:0] r_grant, w_grant_nxt;
  logic       r_underrun, w_underrun_nxt;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_gap_cnt, w_gap_cnt_nxt;
  // Index of the requester served most recently; 1 after reset so that
  // requester 0 wins the first tie.
  logic       r_rr_last, w_rr_last_nxt;
`ifdef TX_SCHED_CHECKSUM_EN
  logic [7:0] r_csum, w_csum_nxt;
`endif

  logic       w_loadable;
  logic       w_consume;
  logic       w_byte_valid;
  logic       w_byte_last;
  logic [7:0] w_byte_data;
  logic       w_accept;
  logic       w_final;
  logic       w_any_req;
  logic       w_pick1;
  logic [7:0] w_header;
  logic       w_gap_slot;
  logic       w_gap_done;

  // The OHR can take a new word if it is empty or being consumed right now.
  assign w_loadable   = !r_d_valid || tx_read_enable;
  assign w_consume    = r_d_valid && tx_read_enable;
  assign w_byte_valid = r_grant[1] ? req1_valid : req0_valid;
  assign w_byte_last  = r_grant[1] ? req1_last  : req0_last;
  assign w_byte_data  = r_grant[1] ? req1_data  : req0_data;
  assign w_accept     = (r_state == S_PAYLOAD) && w_loadable && w_byte_valid;
  // last on the MAX_LEN-th byte closes just this one frame.
  assign w_final      = w_accept && (w_byte_last || (r_cnt == 8'(MAX_LEN - 1)));
  assign w_any_req    = req0_valid || req1_valid;
  assign w_pick1      = req1_valid && (!req0_valid || !r_rr_last);
  assign w_header     = {4'hA, 3'b000, w_pick1};
  // Gap slots are strobes that find the OHR empty; the strobe consuming the
  // final frame word is not part of the gap.
  assign w_gap_slot   = (r_state == S_GAP) && tx_read_enable && !r_d_valid;
  assign w_gap_done   = w_gap_slot && (r_gap_cnt == 4'(GAP_WORDS - 1));

  assign req0_ready   = !rst && (r_state == S_PAYLOAD) && r_grant[0] && w_loadable;
  assign req1_ready   = !rst && (r_state == S_PAYLOAD) && r_grant[1] && w_loadable;

  assign tx_d_in       = r_d_in;
  assign tx_d_in_valid = r_d_valid;
  assign tx_prbs_on    = r_prbs_on;
  assign grant         = r_grant;
  assign underrun      = r_underrun;
  assign o_dbg_state   = r_state;

  // State register.
  always_ff @(posedge clk_bit) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state selection.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (prbs_req)       w_state_nxt = S_PRBS;
        else if (w_any_req) w_state_nxt = S_HEADER;
      end
      S_HEADER: if (w_consume) w_state_nxt = S_PAYLOAD;
      S_PAYLOAD: begin
        if (w_final) begin
`ifdef TX_SCHED_CHECKSUM_EN
          w_state_nxt = S_TRAILER;
`else
          w_state_nxt = S_GAP;
`endif
        end
      end
`ifdef TX_SCHED_CHECKSUM_EN
      S_TRAILER: if (w_loadable) w_state_nxt = S_GAP;
`endif
      S_GAP:  if (w_gap_done) w_state_nxt = S_IDLE;
      S_PRBS: if (!prbs_req)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath registers.
  always_comb begin
    w_d_in_nxt     = w_consume ? 8'h00 : r_d_in;
    w_d_valid_nxt  = r_d_valid && !tx_read_enable;
    w_prbs_on_nxt  = 1'b0;
    w_grant_nxt    = r_grant;
    w_underrun_nxt = 1'b0;
    w_cnt_nxt      = r_cnt;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_rr_last_nxt  = r_rr_last;
`ifdef TX_SCHED_CHECKSUM_EN
    w_csum_nxt     = r_csum;
`endif
    case (r_state)
      S_IDLE: begin
        if (prbs_req) begin
          w_prbs_on_nxt = 1'b1;
        end else if (w_any_req) begin
          w_d_in_nxt    = w_header;
          w_d_valid_nxt = 1'b1;
          w_grant_nxt   = w_pick1 ? 2'b10 : 2'b01;
          w_cnt_nxt     = 8'd0;
          w_gap_cnt_nxt = 4'd0;
`ifdef TX_SCHED_CHECKSUM_EN
          w_csum_nxt    = w_header;
`endif
        end
      end
      S_PAYLOAD: begin
        w_underrun_nxt = tx_read_enable && !r_d_valid;
        if (w_accept) begin
          w_d_in_nxt    = w_byte_data;
          w_d_valid_nxt = 1'b1;
          w_cnt_nxt     = r_cnt + 8'd1;
`ifdef TX_SCHED_CHECKSUM_EN
          w_csum_nxt    = r_csum ^ w_byte_data;
`endif
        end
      end
`ifdef TX_SCHED_CHECKSUM_EN
      S_TRAILER: begin
        if (w_loadable) begin
          w_d_in_nxt    = r_csum;
          w_d_valid_nxt = 1'b1;
        end
      end
`endif
      S_GAP: begin
        if (w_gap_slot) begin
          if (w_gap_done) begin
            w_gap_cnt_nxt = 4'd0;
            w_grant_nxt   = 2'b00;
            w_rr_last_nxt = r_grant[1];
          end else begin
            w_gap_cnt_nxt = r_gap_cnt + 4'd1;
          end
        end
      end
      S_PRBS: w_prbs_on_nxt = prbs_req;
      default: ;
    endcase
  end

  // Registered outputs and datapath; reset abandons any frame in progress.
  always_ff @(posedge clk_bit) begin
    if (rst) begin
      r_d_in     <= 8'h00;
      r_d_valid  <= 1'b0;
      r_prbs_on  <= 1'b0;
      r_grant    <= 2'b00;
      r_underrun <= 1'b0;
      r_cnt      <= 8'd0;
      r_gap_cnt  <= 4'd0;
      r_rr_last  <= 1'b1;
`ifdef TX_SCHED_CHECKSUM_EN
      r_csum     <= 8'h00;
`endif
    end else begin
      r_d_in     <= w_d_in_nxt;
      r_d_valid  <= w_d_valid_nxt;
      r_prbs_on  <= w_prbs_on_nxt;
      r_grant    <= w_grant_nxt;
      r_underrun <= w_underrun_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
      r_rr_last  <= w_rr_last_nxt;
`ifdef TX_SCHED_CHECKSUM_EN
      r_csum     <= w_csum_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Bench for tx_frame_scheduler: frame-level model of the line plus directed
// literal expectations. Build with TX_SCHED_CHECKSUM_EN to cover the trailer.
module tb_tx_frame_scheduler;
  localparam int MAX_LEN   = 64;
  localparam int GAP_WORDS = 2;
`ifdef TX_SCHED_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       clk_bit = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
  logic       req0_valid = 1'b0, req0_last = 1'b0, req1_valid = 1'b0, req1_last = 1'b0;
  logic       req0_ready, req1_ready;
  logic       prbs_req = 1'b0;
  logic       tx_read_enable = 1'b0;
  logic [7:0] tx_d_in;
  logic       tx_d_in_valid, tx_prbs_on, underrun;
  logic [1:0] grant;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  tx_frame_scheduler #(.MAX_LEN(MAX_LEN), .GAP_WORDS(GAP_WORDS)) dut (
    .clk_bit(clk_bit), .rst(rst),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .prbs_req(prbs_req), .tx_read_enable(tx_read_enable),
    .tx_d_in(tx_d_in), .tx_d_in_valid(tx_d_in_valid), .tx_prbs_on(tx_prbs_on),
    .grant(grant), .underrun(underrun), .o_dbg_state(dbg_state)
  );

  // Clock and tx read strobe (one cycle in ten, changed on the falling edge).
  always #5 clk_bit = ~clk_bit;
  int strobe_ph = 0;
  initial forever begin
    @(negedge clk_bit);
    strobe_ph = (strobe_ph == 9) ? 0 : strobe_ph + 1;
    tx_read_enable = (strobe_ph == 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_bit);
    #2;
  endtask

  // ---------------- model: expected line words {grant, word} ----------------
  logic [9:0] exp_q[$];
  int         exp_len_q[$];

  task automatic model_frame(input logic own, input logic [7:0] bytes[$]);
    logic [1:0] g;
    logic [7:0] hdr;
    logic [7:0] cs;
    g   = own ? 2'b10 : 2'b01;
    hdr = {4'hA, 3'b000, own};
    cs  = hdr;
    exp_q.push_back({g, hdr});
    foreach (bytes[i]) begin
      exp_q.push_back({g, bytes[i]});
      cs = cs ^ bytes[i];
    end
    if (CS == 1) exp_q.push_back({g, cs});
    exp_len_q.push_back(1 + bytes.size() + CS);
  endtask

  // Splits one requester's byte stream into frames: a frame ends on last or
  // when it reaches MAX_LEN bytes.
  task automatic model_stream(input logic own, input logic [7:0] d[$], input logic l[$]);
    logic [7:0] fr[$];
    foreach (d[i]) begin
      fr.push_back(d[i]);
      if (l[i] || fr.size() == MAX_LEN) begin
        model_frame(own, fr);
        fr.delete();
      end
    end
  endtask

  // ---------------- drivers ----------------
  logic abort = 1'b0;

  task automatic set_req(input logic who, input logic v, input logic [7:0] dd, input logic ll);
    if (who) begin req1_valid = v; req1_data = dd; req1_last = ll; end
    else     begin req0_valid = v; req0_data = dd; req0_last = ll; end
  endtask

  task automatic drive(input logic who, input logic [7:0] d[$], input logic l[$],
                       input int hold_after, input int hold_cycles);
    int waited;
    @(negedge clk_bit);
    for (int i = 0; i < d.size(); i++) begin
      if (i == hold_after && hold_cycles > 0) begin
        set_req(who, 1'b0, 8'h00, 1'b0);
        repeat (hold_cycles) @(negedge clk_bit);
      end
      set_req(who, 1'b1, d[i], l[i]);
      waited = 0;
      forever begin
        #4;
        if (abort) begin
          set_req(who, 1'b0, 8'h00, 1'b0);
          return;
        end
        if (who ? req1_ready : req0_ready) begin
          @(negedge clk_bit);
          break;
        end
        @(negedge clk_bit);
        waited++;
        if (waited > 3000) begin
          n_checks++; n_errors++;
          $display("FAIL drive%0d_timeout: byte %0d not accepted, waited %0d cycles", who, i, waited);
          set_req(who, 1'b0, 8'h00, 1'b0);
          return;
        end
      end
    end
    set_req(who, 1'b0, 8'h00, 1'b0);
  endtask

  // ---------------- compare process ----------------
  int         rem = 0;
  int         idle_since_end = 0;
  int         in_frame_idle = 0;
  int         ur_cnt = 0;
  int         busy_cycles = 0;
  logic       had_frame = 1'b0;
  int         gap_log[$];
  logic [7:0] line_log[$];

  initial forever begin
    logic [9:0] e;
    @(negedge clk_bit);
    #4;
    if (rst) begin
      exp_q.delete(); exp_len_q.delete();
      rem = 0; had_frame = 1'b0; idle_since_end = 0;
      continue;
    end
    if (underrun) ur_cnt++;
    if (grant != 2'b00 || tx_prbs_on || tx_d_in_valid) busy_cycles++;
    if (tx_prbs_on) check("prbs_ohr_idle", tx_d_in_valid, 0);
    if (tx_read_enable) begin
      if (tx_d_in_valid) begin
        line_log.push_back(tx_d_in);
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_word: got 0x%0h expected no word", tx_d_in);
        end else begin
          e = exp_q.pop_front();
          check("line_word", tx_d_in, e[7:0]);
          check("line_grant", grant, e[9:8]);
          if (rem == 0) begin
            if (had_frame) begin
              gap_log.push_back(idle_since_end);
              check("gap_min", idle_since_end >= GAP_WORDS, 1);
            end
            rem = (exp_len_q.size() > 0) ? exp_len_q.pop_front() : 1;
          end
          rem--;
          if (rem == 0) begin
            had_frame = 1'b1;
            idle_since_end = 0;
          end
        end
      end else begin
        if (rem > 0) in_frame_idle++;
        else         idle_since_end++;
      end
    end
  end

  task automatic wait_drain(input string name, input int extra_cycles);
    int budget;
    budget = 0;
    while ((exp_q.size() != 0 || rem != 0) && budget < 5000) begin
      tick();
      budget++;
    end
    if (budget >= 5000) begin
      n_checks++; n_errors++;
      $display("FAIL %s_drain: %0d words outstanding, expected 0", name, exp_q.size());
    end
    repeat (extra_cycles) tick();
  endtask

  task automatic pulse_reset();
    @(negedge clk_bit); rst = 1'b1;
    repeat (2) @(negedge clk_bit);
    rst = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [7:0] d[$];
    logic       l[$];
    logic [7:0] d1[$];
    logic       l1[$];
    int         budget;

    // Reset and quiet line.
    repeat (3) @(negedge clk_bit);
    #2;
    check("rst_d_in", tx_d_in, 8'h00);
    check("rst_valid", tx_d_in_valid, 0);
    check("rst_prbs", tx_prbs_on, 0);
    check("rst_grant", grant, 2'b00);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_underrun", underrun, 0);
    check("rst_state", dbg_state, 3'd0);
    @(negedge clk_bit); rst = 1'b0;
    busy_cycles = 0;
    repeat (1000) tick();
    check("t1_busy_cycles", busy_cycles, 0);
    check("t1_words", line_log.size(), 0);

    // Single req0 frame.
    line_log.delete(); gap_log.delete();
    d = '{8'h01, 8'h02, 8'h03};
    l = '{1'b0, 1'b0, 1'b1};
    model_stream(1'b0, d, l);
    drive(1'b0, d, l, -1, 0);
    wait_drain("t2", 10 * (GAP_WORDS + 1));
    check("t2_len", line_log.size(), 4 + CS);
    check("t2_hdr", line_log[0], 8'hA0);
    check("t2_b1", line_log[1], 8'h01);
    check("t2_b3", line_log[3], 8'h03);
`ifdef TX_SCHED_CHECKSUM_EN
    check("t2_csum", line_log[4], 8'hA0);
`endif

    // Round robin from reset: req0, req1, req0.
    pulse_reset();
    line_log.delete(); gap_log.delete();
    d  = '{8'h10, 8'h11, 8'h12, 8'h13};
    l  = '{1'b0, 1'b1, 1'b0, 1'b1};
    d1 = '{8'h20, 8'h21};
    l1 = '{1'b0, 1'b1};
    model_frame(1'b0, '{8'h10, 8'h11});
    model_frame(1'b1, '{8'h20, 8'h21});
    model_frame(1'b0, '{8'h12, 8'h13});
    fork
      drive(1'b0, d, l, -1, 0);
      drive(1'b1, d1, l1, -1, 0);
    join
    wait_drain("t3", 10 * (GAP_WORDS + 1));
    check("t3_hdr0", line_log[0], 8'hA0);
    check("t3_hdr1", line_log[3 + CS], 8'hA1);
    check("t3_hdr2", line_log[6 + 2 * CS], 8'hA0);
    check("t3_gaps", gap_log.size(), 2);
    check("t3_gap0", gap_log[0], 2);
    check("t3_gap1", gap_log[1], 2);

    // req1 streams 70 bytes; MAX_LEN splits it 64 + 6.
    line_log.delete();
    d1.delete(); l1.delete();
    for (int i = 0; i < 70; i++) begin
      d1.push_back(8'(i + 1));
      l1.push_back(i == 69);
    end
    model_stream(1'b1, d1, l1);
    drive(1'b1, d1, l1, -1, 0);
    wait_drain("t4", 10 * (GAP_WORDS + 1));
    check("t4_len", line_log.size(), 65 + CS + 7 + CS);
    check("t4_byte64", line_log[64], 8'h40);
    check("t4_hdr2", line_log[65 + CS], 8'hA1);
    check("t4_byte65", line_log[66 + CS], 8'h41);

    // Requester stalls mid-payload: each empty slot pulses underrun.
    ur_cnt = 0; in_frame_idle = 0;
    d.delete(); l.delete();
    for (int i = 0; i < 10; i++) begin
      d.push_back(8'(8'h30 + i));
      l.push_back(i == 9);
    end
    model_stream(1'b0, d, l);
    drive(1'b0, d, l, 4, 25);
    wait_drain("t5", 10 * (GAP_WORDS + 1));
    check("t5_underrun_vs_idle", ur_cnt, in_frame_idle);
    check("t5_underrun_seen", ur_cnt >= 1, 1);

    // PRBS raised mid-frame waits for frame and gap.
    d = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    model_stream(1'b0, d, l);
    fork
      drive(1'b0, d, l, -1, 0);
      begin
        repeat (30) @(negedge clk_bit);
        prbs_req = 1'b1;
      end
    join
    wait_drain("t6", 0);
    check("t6_prbs_held", tx_prbs_on, 0);
    budget = 0;
    while (!tx_prbs_on && budget < 200) begin
      tick();
      budget++;
    end
    check("t6_prbs_on", tx_prbs_on, 1);
    check("t6_gap_before_prbs", idle_since_end, GAP_WORDS);
    repeat (50) tick();
    check("t6_prbs_still_on", tx_prbs_on, 1);
    @(negedge clk_bit); prbs_req = 1'b0;
    #2;
    check("t6_prbs_before_edge", tx_prbs_on, 1);
    tick();
    check("t6_prbs_off", tx_prbs_on, 0);
    repeat (10) tick();

    // Reset mid-frame clears all outputs on the next edge.
    d.delete(); l.delete();
    for (int i = 0; i < 20; i++) begin
      d.push_back(8'(8'h60 + i));
      l.push_back(i == 19);
    end
    model_stream(1'b0, d, l);
    fork
      drive(1'b0, d, l, -1, 0);
      begin
        repeat (45) tick();
        check("t7_grant_mid", grant, 2'b01);
        @(negedge clk_bit); rst = 1'b1; abort = 1'b1;
        @(negedge clk_bit); rst = 1'b0;
        #2;
        check("t7_valid", tx_d_in_valid, 0);
        check("t7_d_in", tx_d_in, 8'h00);
        check("t7_grant", grant, 2'b00);
        check("t7_prbs", tx_prbs_on, 0);
        check("t7_ready0", req0_ready, 0);
      end
    join
    abort = 1'b0;
    line_log.delete();
    repeat (100) tick();
    check("t7_quiet", line_log.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
